// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer slice.
//   fetch_state_t : sequencer state encoding (IDLE / FETCH / HALTED)
//   fetch_entry_t : one prefetch FIFO entry, {pc, instr}
//   pc_inc        : next sequential fetch address, wraps modulo 2^PC_W
package fetch_sequencer_pkg;

  localparam int PC_W       = 8;
  localparam int INSTR_W    = 24;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential next PC; 8'hFF rolls over to 8'h00 with no flag.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode-side valid/ready handshake of the fetch sequencer.
//   out_valid : head entry valid          (master -> slave)
//   out_instr : head instruction word     (master -> slave)
//   out_pc    : PC of head instruction    (master -> slave)
//   out_ready : decode accepts head entry (slave -> master)
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_sequencer_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write din when not full, or when full and a pop happens the same edge
//   pop        : drop the head entry when not empty
//   flush      : empty the FIFO; overrides push and pop
//   full/empty : occupancy flags
//   head       : oldest entry, read straight from the storage registers
module fetch_sequencer_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign pop_ok_s  = pop & ~empty & ~flush;
  // A full FIFO can still accept a write when the head leaves on the same edge.
  assign push_ok_s = push & (~full | pop_ok_s) & ~flush;
  assign head      = mem_r[rd_ptr_r];

  // Entry storage: data needs no reset, occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and prefetch buffer for a combinational-read imem.
//   clk, reset        : clock, synchronous active-high reset
//   start, start_pc   : begin fetching at start_pc (honoured in IDLE / HALTED)
//   imem_pc           : fetch address (the fetch PC register)
//   imem_instr        : word returned combinationally for imem_pc
//   dec               : decode handshake (out_valid/out_instr/out_pc/out_ready)
//   redirect, redirect_pc : flush prefetch buffer and refetch from redirect_pc
//   halt              : stop fetching; buffered entries still drain
//   busy / halted     : state is FETCH / HALTED
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              DEPTH    = FIFO_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_W-1:0]     start_pc,
  output logic [PC_W-1:0]     imem_pc,
  input  logic [INSTR_W-1:0]  imem_instr,
  fetch_sequencer_if.master   dec,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                halt,
  output logic                busy,
  output logic                halted
);

  fetch_state_t    state_r, state_n_s;
  logic [PC_W-1:0] fetch_pc_r, fetch_pc_n_s;
  logic            push_s;
  logic            flush_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  fetch_entry_t    head_s;
  fetch_entry_t    din_s;

  assign pop_s         = ~empty_s & dec.out_ready;
  assign din_s         = '{pc: fetch_pc_r, instr: imem_instr};
  assign dec.out_valid = ~empty_s;
  assign dec.out_pc    = head_s.pc;
  assign dec.out_instr = head_s.instr;
  assign imem_pc       = fetch_pc_r;
  assign busy          = (state_r == FETCH);
  assign halted        = (state_r == HALTED);

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
    end else begin
      state_r    <= state_n_s;
      fetch_pc_r <= fetch_pc_n_s;
    end
  end

  // Next state, next PC and FIFO control; priority redirect > halt > start > enqueue.
  always_comb begin
    state_n_s    = state_r;
    fetch_pc_n_s = fetch_pc_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n_s    = FETCH;
          fetch_pc_n_s = start_pc;
        end else begin
          state_n_s    = IDLE;
        end
      end
      FETCH: begin
        if (redirect) begin
          flush_s      = 1'b1;
          fetch_pc_n_s = redirect_pc;
        end else if (halt) begin
          state_n_s    = HALTED;
        end else if (~full_s || pop_s) begin
          push_s       = 1'b1;
          fetch_pc_n_s = pc_inc(fetch_pc_r);
        end else begin
          // Buffer full and head not taken: hold the fetch PC.
          push_s       = 1'b0;
        end
      end
      HALTED: begin
        if (redirect) begin
          flush_s      = 1'b1;
          fetch_pc_n_s = redirect_pc;
        end else if (start) begin
          // Restart keeps whatever is still buffered.
          state_n_s    = FETCH;
          fetch_pc_n_s = start_pc;
        end else begin
          state_n_s    = HALTED;
        end
      end
      default: begin
        state_n_s    = IDLE;
        fetch_pc_n_s = RESET_PC;
      end
    endcase
  end

  fetch_sequencer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (din_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

endmodule
